// File: rtl/jtdd2_snd_romfetch.sv
// jtdd2_snd_romfetch: arbitrates the Z80 and ADPCM ROM clients onto one 16-bit SDRAM read port, with a one-word hit cache for each client
module jtdd2_snd_romfetch #(
    parameter logic [21:0] MAIN_OFFSET = 22'h00_0000,
    parameter logic [21:0] PCM_OFFSET  = 22'h01_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        main_cs,
    input  logic [14:0] main_addr,
    output logic [7:0]  main_data,
    output logic        main_ok,
    input  logic        pcm_cs,
    input  logic [17:0] pcm_addr,
    output logic [7:0]  pcm_data,
    output logic        pcm_ok,
    output logic        sdram_req,
    output logic [21:0] sdram_addr,
    input  logic        sdram_ack,
    input  logic        sdram_rdy,
    input  logic [15:0] sdram_data
);
    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;
    state_t      state_q;
    logic        main_valid_q, pcm_valid_q;
    logic [13:0] main_tag_q;
    logic [16:0] pcm_tag_q;
    logic [15:0] main_word_q, pcm_word_q;
    logic        last_pcm_q, gnt_pcm_q;
    logic [16:0] gnt_tag_q;
    logic        main_miss, pcm_miss, pick_pcm, fill;
    logic [21:0] main_req_addr, pcm_req_addr;
    // hit detection, byte selection and arbitration are all combinational
    always_comb begin
        main_ok       = main_cs && main_valid_q && main_tag_q == main_addr[14:1];
        pcm_ok        = pcm_cs && pcm_valid_q && pcm_tag_q == pcm_addr[17:1];
        main_data     = main_addr[0] ? main_word_q[15:8] : main_word_q[7:0];
        pcm_data      = pcm_addr[0] ? pcm_word_q[15:8] : pcm_word_q[7:0];
        main_miss     = main_cs && !main_ok;
        pcm_miss      = pcm_cs && !pcm_ok;
        pick_pcm      = pcm_miss && (!main_miss || !last_pcm_q);
        main_req_addr = MAIN_OFFSET + {8'd0, main_addr[14:1]};
        pcm_req_addr  = PCM_OFFSET + {5'd0, pcm_addr[17:1]};
        fill          = sdram_rdy && (state_q == WAIT_DATA || (state_q == WAIT_ACK && sdram_ack));
    end
    // request FSM plus cache fill of the granted client only
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sdram_req    <= 1'b0;
            sdram_addr   <= 22'd0;
            main_valid_q <= 1'b0;
            pcm_valid_q  <= 1'b0;
            main_tag_q   <= 14'd0;
            pcm_tag_q    <= 17'd0;
            main_word_q  <= 16'd0;
            pcm_word_q   <= 16'd0;
            last_pcm_q   <= 1'b1;
            gnt_pcm_q    <= 1'b0;
            gnt_tag_q    <= 17'd0;
        end else begin
            case (state_q)
                IDLE: if (main_miss || pcm_miss) begin
                    state_q    <= WAIT_ACK;
                    sdram_req  <= 1'b1;
                    sdram_addr <= pick_pcm ? pcm_req_addr : main_req_addr;
                    gnt_pcm_q  <= pick_pcm;
                    last_pcm_q <= pick_pcm;
                    gnt_tag_q  <= pick_pcm ? pcm_addr[17:1] : {3'd0, main_addr[14:1]};
                end
                WAIT_ACK: if (sdram_ack) begin
                    sdram_req <= 1'b0;
                    state_q   <= sdram_rdy ? IDLE : WAIT_DATA;
                end
                WAIT_DATA: if (sdram_rdy) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            if (fill && gnt_pcm_q) begin
                pcm_word_q  <= sdram_data;
                pcm_tag_q   <= gnt_tag_q;
                pcm_valid_q <= 1'b1;
            end
            if (fill && !gnt_pcm_q) begin
                main_word_q  <= sdram_data;
                main_tag_q   <= gnt_tag_q[13:0];
                main_valid_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_jtdd2_snd_romfetch.sv
// tb_jtdd2_snd_romfetch: directed checks of the sound ROM fetcher
module tb_jtdd2_snd_romfetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        main_cs = 1'b0;
    logic [14:0] main_addr = 15'd0;
    logic [7:0]  main_data;
    logic        main_ok;
    logic        pcm_cs = 1'b0;
    logic [17:0] pcm_addr = 18'd0;
    logic [7:0]  pcm_data;
    logic        pcm_ok;
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic        sdram_ack = 1'b0;
    logic        sdram_rdy = 1'b0;
    logic [15:0] sdram_data = 16'd0;
    int vectors = 0;
    int miscompares = 0;

    jtdd2_snd_romfetch dut (
        .clk(clk), .rst_n(rst_n),
        .main_cs(main_cs), .main_addr(main_addr), .main_data(main_data), .main_ok(main_ok),
        .pcm_cs(pcm_cs), .pcm_addr(pcm_addr), .pcm_data(pcm_data), .pcm_ok(pcm_ok),
        .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
        .sdram_rdy(sdram_rdy), .sdram_data(sdram_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; main_cs = 1'b1; main_addr = 15'h0100; pcm_cs = 1'b0;
        repeat (3) tick();
        vectors++; if (sdram_req !== 1'b0) begin miscompares++; $display("FAIL reset_req got %b want 0", sdram_req); end
        vectors++; if (main_ok !== 1'b0) begin miscompares++; $display("FAIL reset_main_ok got %b want 0", main_ok); end
        vectors++; if (main_data !== 8'h00) begin miscompares++; $display("FAIL reset_main_data got %h want 00", main_data); end
        rst_n = 1'b1;
        tick();
        vectors++; if (sdram_req !== 1'b1) begin miscompares++; $display("FAIL first_req got %b want 1", sdram_req); end
        vectors++; if (sdram_addr !== 22'h000080) begin miscompares++; $display("FAIL first_addr got %h want 000080", sdram_addr); end
    endtask

    task automatic test_seq_hit();
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        vectors++; if (sdram_req !== 1'b0) begin miscompares++; $display("FAIL ack_drops_req got %b want 0", sdram_req); end
        repeat (3) tick();
        vectors++; if (main_ok !== 1'b0) begin miscompares++; $display("FAIL ok_before_rdy got %b want 0", main_ok); end
        sdram_rdy = 1'b1; sdram_data = 16'hBEEF;
        tick();
        sdram_rdy = 1'b0; sdram_data = 16'd0;
        vectors++; if (main_ok !== 1'b1) begin miscompares++; $display("FAIL hit_ok got %b want 1", main_ok); end
        vectors++; if (main_data !== 8'hEF) begin miscompares++; $display("FAIL hit_lo got %h want EF", main_data); end
        main_addr = 15'h0101;
        #1;
        vectors++; if (main_ok !== 1'b1) begin miscompares++; $display("FAIL seq_ok got %b want 1", main_ok); end
        vectors++; if (main_data !== 8'hBE) begin miscompares++; $display("FAIL seq_hi got %h want BE", main_data); end
        tick();
        vectors++; if (sdram_req !== 1'b0) begin miscompares++; $display("FAIL seq_no_req got %b want 0", sdram_req); end
    endtask

    task automatic test_contention();
        rst_n = 1'b0; main_cs = 1'b1; main_addr = 15'h0100; pcm_cs = 1'b1; pcm_addr = 18'h00200;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        vectors++; if (sdram_addr !== 22'h000080) begin miscompares++; $display("FAIL cont_main_first got %h want 000080", sdram_addr); end
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0; sdram_rdy = 1'b1; sdram_data = 16'h1234;
        tick();
        sdram_rdy = 1'b0; sdram_data = 16'd0;
        vectors++; if (main_ok !== 1'b1 || main_data !== 8'h34) begin miscompares++; $display("FAIL cont_main_fill got ok=%b data=%h want ok=1 data=34", main_ok, main_data); end
        vectors++; if (pcm_ok !== 1'b0) begin miscompares++; $display("FAIL cont_pcm_untouched got %b want 0", pcm_ok); end
        tick();
        vectors++; if (sdram_req !== 1'b1 || sdram_addr !== 22'h010100) begin miscompares++; $display("FAIL cont_pcm_req got req=%b addr=%h want req=1 addr=010100", sdram_req, sdram_addr); end
    endtask

    task automatic test_ack_rdy_same();
        sdram_ack = 1'b1; sdram_rdy = 1'b1; sdram_data = 16'h5678;
        tick();
        sdram_ack = 1'b0; sdram_rdy = 1'b0; sdram_data = 16'd0;
        vectors++; if (pcm_ok !== 1'b1 || pcm_data !== 8'h78) begin miscompares++; $display("FAIL same_fill got ok=%b data=%h want ok=1 data=78", pcm_ok, pcm_data); end
        vectors++; if (sdram_req !== 1'b0) begin miscompares++; $display("FAIL same_req got %b want 0", sdram_req); end
        vectors++; if (main_ok !== 1'b1 || main_data !== 8'h34) begin miscompares++; $display("FAIL same_main_kept got ok=%b data=%h want ok=1 data=34", main_ok, main_data); end
        tick();
        vectors++; if (sdram_req !== 1'b0) begin miscompares++; $display("FAIL same_idle got %b want 0", sdram_req); end
    endtask

    task automatic test_addr_change();
        pcm_cs = 1'b0; main_addr = 15'h0010;
        tick();
        vectors++; if (sdram_req !== 1'b1 || sdram_addr !== 22'h000008) begin miscompares++; $display("FAIL chg_req1 got req=%b addr=%h want req=1 addr=000008", sdram_req, sdram_addr); end
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0; main_addr = 15'h0020; sdram_rdy = 1'b1; sdram_data = 16'hAAAA;
        tick();
        sdram_rdy = 1'b0; sdram_data = 16'd0;
        vectors++; if (main_ok !== 1'b0) begin miscompares++; $display("FAIL chg_ok_low got %b want 0", main_ok); end
        tick();
        vectors++; if (sdram_req !== 1'b1 || sdram_addr !== 22'h000010) begin miscompares++; $display("FAIL chg_req2 got req=%b addr=%h want req=1 addr=000010", sdram_req, sdram_addr); end
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0; sdram_rdy = 1'b1; sdram_data = 16'h1357;
        tick();
        sdram_rdy = 1'b0; sdram_data = 16'd0;
        vectors++; if (main_ok !== 1'b1 || main_data !== 8'h57) begin miscompares++; $display("FAIL chg_fill got ok=%b data=%h want ok=1 data=57", main_ok, main_data); end
    endtask

    task automatic test_reset_mid_fetch();
        main_cs = 1'b0; pcm_cs = 1'b1; pcm_addr = 18'h00401;
        tick();
        vectors++; if (sdram_req !== 1'b1 || sdram_addr !== 22'h010200) begin miscompares++; $display("FAIL rmf_req got req=%b addr=%h want req=1 addr=010200", sdram_req, sdram_addr); end
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0; rst_n = 1'b0;
        tick();
        vectors++; if (sdram_req !== 1'b0 || pcm_ok !== 1'b0 || pcm_data !== 8'h00) begin miscompares++; $display("FAIL rmf_reset got req=%b ok=%b data=%h want req=0 ok=0 data=00", sdram_req, pcm_ok, pcm_data); end
        rst_n = 1'b1; sdram_rdy = 1'b1; sdram_data = 16'hFFFF;
        tick();
        sdram_rdy = 1'b0; sdram_data = 16'd0;
        vectors++; if (pcm_ok !== 1'b0 || pcm_data !== 8'h00) begin miscompares++; $display("FAIL rmf_stray got ok=%b data=%h want ok=0 data=00", pcm_ok, pcm_data); end
        vectors++; if (sdram_req !== 1'b1 || sdram_addr !== 22'h010200) begin miscompares++; $display("FAIL rmf_reissue got req=%b addr=%h want req=1 addr=010200", sdram_req, sdram_addr); end
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0; sdram_rdy = 1'b1; sdram_data = 16'hC3A5;
        tick();
        sdram_rdy = 1'b0; sdram_data = 16'd0;
        vectors++; if (pcm_ok !== 1'b1 || pcm_data !== 8'hC3) begin miscompares++; $display("FAIL rmf_fill got ok=%b data=%h want ok=1 data=C3", pcm_ok, pcm_data); end
    endtask

    initial begin
        test_reset();
        test_seq_hit();
        test_contention();
        test_ack_rdy_same();
        test_addr_change();
        test_reset_mid_fetch();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
